// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter that shares one external combinational 32-bit adder
// among N_REQ requesters. Each accepted request walks IDLE -> ISSUE -> DONE (one add per 3 cycles).
module adder_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [32*N_REQ-1:0] op_a,
  input  logic [32*N_REQ-1:0] op_b,
  output logic [N_REQ-1:0]    gnt,
  output logic [31:0]         add_a,
  output logic [31:0]         add_b,
  input  logic [31:0]         add_s,
  input  logic                add_c,
  output logic [31:0]         sum,
  output logic                carry,
  output logic                done,
  output logic [IDX_W-1:0]    done_id,
  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_last;
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] r_done_id;
  logic [N_REQ-1:0] r_gnt;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic [31:0]      r_sum;
  logic             r_carry;

  logic [IDX_W-1:0] w_win_idx;
  logic [IDX_W-1:0] w_cand;
  logic             w_win_found;
  logic [N_REQ-1:0] w_win_oh;
  logic [31:0]      w_op_a_arr [N_REQ];
  logic [31:0]      w_op_b_arr [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign w_op_a_arr[gi] = op_a[32*gi +: 32];
      assign w_op_b_arr[gi] = op_b[32*gi +: 32];
      assign w_win_oh[gi]   = (w_win_idx == IDX_W'(gi));
    end
  endgenerate

  // Scan from farthest to nearest so the requester closest after r_last wins.
  always_comb begin
    w_win_idx   = '0;
    w_win_found = 1'b0;
    w_cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      w_cand = IDX_W'((32'(r_last) + 32'(k)) % N_REQ);
      if (req[w_cand]) begin
        w_win_idx   = w_cand;
        w_win_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_win_found) w_state_next = S_ISSUE;
      S_ISSUE: w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gnt     <= '0;
      r_op_a    <= '0;
      r_op_b    <= '0;
      r_idx     <= '0;
      r_last    <= IDX_W'(N_REQ - 1);
      r_sum     <= '0;
      r_carry   <= 1'b0;
      r_done_id <= '0;
    end else begin
      r_gnt <= '0;
      if (r_state == S_IDLE && w_win_found) begin
        r_gnt  <= w_win_oh;
        r_op_a <= w_op_a_arr[w_win_idx];
        r_op_b <= w_op_b_arr[w_win_idx];
        r_idx  <= w_win_idx;
        r_last <= w_win_idx;
      end
      // The external adder sees r_op_a/r_op_b during ISSUE; its result is taken at the end of it.
      if (r_state == S_ISSUE) begin
        r_sum     <= add_s;
        r_carry   <= add_c;
        r_done_id <= r_idx;
      end
    end
  end

  assign gnt     = r_gnt;
  assign add_a   = r_op_a;
  assign add_b   = r_op_b;
  assign sum     = r_sum;
  assign carry   = r_carry;
  assign done_id = r_done_id;
  assign done    = (r_state == S_DONE);
  assign busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: transaction-level reference model (scheduled grant/done cycles),
// per-cycle output compare, directed scenarios with literal expectations, then random traffic.
module tb_adder_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [32*N-1:0] op_a, op_b;
  logic [N-1:0]   gnt;
  logic [31:0]    add_a, add_b, add_s;
  logic           add_c;
  logic [31:0]    sum;
  logic           carry, done, busy;
  logic [1:0]     done_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // The shared external adder.
  assign {add_c, add_s} = {1'b0, add_a} + {1'b0, add_b};

  adder_arbiter #(.N_REQ(N)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_c(add_c),
    .sum(sum), .carry(carry), .done(done), .done_id(done_id), .busy(busy)
  );

  // Reference model: each accepted request is a scheduled transaction (grant cycle, done cycle).
  int          m_edge = 0;
  bit          m_valid = 0;
  int          m_last, m_next, m_gnt_cyc = -10, m_done_cyc = -10, m_win = 0;
  logic [31:0] m_add_a = 0, m_add_b = 0, m_sum = 0, p_sum = 0;
  logic        m_carry = 0, p_carry = 0;
  logic [1:0]  m_id = 0, p_id = 0;
  logic [N-1:0] exp_gnt;
  logic        exp_done, exp_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=0x%08h expected=0x%08h", name, m_edge, act, exp);
    end
  endtask

  // Called with the inputs for the coming rising edge already applied.
  task automatic model_edge();
    int w;
    m_edge++;
    if (rst) begin
      m_valid = 1;
      m_last = N - 1; m_next = m_edge + 1;
      m_gnt_cyc = -10; m_done_cyc = -10;
      m_sum = 0; m_carry = 0; m_id = 0; m_add_a = 0; m_add_b = 0;
    end else begin
      if (m_edge == m_done_cyc) begin
        m_sum = p_sum; m_carry = p_carry; m_id = p_id;
      end
      if (m_edge >= m_next && req != '0) begin
        w = -1;
        for (int k = 1; k <= N; k++)
          if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
        m_win = w; m_last = w;
        m_add_a = op_a[32*w +: 32];
        m_add_b = op_b[32*w +: 32];
        {p_carry, p_sum} = {1'b0, m_add_a} + {1'b0, m_add_b};
        p_id = 2'(w);
        m_gnt_cyc = m_edge; m_done_cyc = m_edge + 1; m_next = m_edge + 3;
      end
    end
    exp_gnt = '0;
    if (m_edge == m_gnt_cyc) exp_gnt[m_win] = 1'b1;
    exp_done = (m_edge == m_done_cyc);
    exp_busy = (m_edge == m_gnt_cyc) || (m_edge == m_done_cyc);
  endtask

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check("gnt", 32'(gnt), 32'(exp_gnt));
      check("done", 32'(done), 32'(exp_done));
      check("busy", 32'(busy), 32'(exp_busy));
      check("sum", sum, m_sum);
      check("carry", 32'(carry), 32'(m_carry));
      check("done_id", 32'(done_id), 32'(m_id));
      check("add_a", add_a, m_add_a);
      check("add_b", add_b, m_add_b);
    end
  end

  task automatic tick();
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    op_a[32*i +: 32] = a;
    op_b[32*i +: 32] = b;
  endtask

  function automatic logic [31:0] rnd();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      default: return $urandom();
    endcase
  endfunction

  initial begin
    rst = 1'b1; req = '0; op_a = '0; op_b = '0;
    @(negedge clk);
    tick();
    check("rst_gnt", 32'(gnt), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sum", sum, 0);
    rst = 1'b0;

    // Single request with wrap-around.
    set_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF); req = 4'b0001;
    tick();
    check("single_gnt", 32'(gnt), 32'h1);
    req = '0;
    tick();
    check("single_done", 32'(done), 1);
    check("single_sum", sum, 32'hFFFF_FFFE);
    check("single_carry", 32'(carry), 1);
    check("single_id", 32'(done_id), 0);
    check("model_sum_pin", m_sum, 32'hFFFF_FFFE);
    tick();

    // Zero operands; busy for exactly two cycles.
    set_op(1, 0, 0); req = 4'b0010;
    tick();
    check("zero_busy1", 32'(busy), 1);
    req = '0;
    tick();
    check("zero_busy2", 32'(busy), 1);
    check("zero_sum", sum, 0);
    check("zero_carry", 32'(carry), 0);
    check("zero_id", 32'(done_id), 1);
    tick();
    check("zero_busy3", 32'(busy), 0);

    // Round-robin skip: last winner 1, req=1001 -> 3 then 0.
    set_op(3, 32'd30, 32'd3); set_op(0, 32'd1, 32'd2); req = 4'b1001;
    tick();
    check("skip_gnt3", 32'(gnt), 32'h8);
    req = 4'b0001;
    tick();
    check("skip_id3", 32'(done_id), 3);
    check("skip_sum3", sum, 32'd33);
    tick();
    tick();
    check("skip_gnt0", 32'(gnt), 32'h1);
    req = '0;
    tick();
    tick();

    // Operand change in the grant cycle must not affect the result.
    set_op(2, 32'd5, 32'd7); req = 4'b0100;
    tick();
    check("chg_gnt", 32'(gnt), 32'h4);
    req = '0; set_op(2, 32'd100, 32'd7);
    tick();
    check("chg_sum", sum, 32'd12);
    check("chg_carry", 32'(carry), 0);
    check("chg_id", 32'(done_id), 2);
    tick();

    // Reset during ISSUE aborts the operation.
    set_op(1, 32'd9, 32'd9); req = 4'b0010;
    tick();
    check("abort_gnt", 32'(gnt), 32'h2);
    rst = 1'b1; req = '0;
    tick();
    check("abort_done", 32'(done), 0);
    check("abort_sum", sum, 0);
    check("abort_add_a", add_a, 0);
    rst = 1'b0;

    // Contention with all requesters holding req: order 0,1,2,3,0.
    for (int i = 0; i < N; i++) set_op(i, 32'h1000_0000 * (i + 1) + i, 32'hF000_0000 + 3 * i);
    req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      tick();
      check("rr_gnt", 32'(gnt), 32'(1 << (t % N)));
      tick();
      check("rr_done", 32'(done), 1);
      check("rr_id", 32'(done_id), 32'(t % N));
      tick();
    end
    req = '0;
    tick();
    tick();

    // Random traffic with occasional resets, abandoned requests and operand changes.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        if (req[i] && gnt[i]) begin
          req[i] = 1'b0;
          if ($urandom_range(0, 1) == 1) set_op(i, rnd(), rnd());
        end else if (req[i]) begin
          if ($urandom_range(0, 24) == 0) req[i] = 1'b0;
          else if ($urandom_range(0, 7) == 0) set_op(i, rnd(), rnd());
        end else if ($urandom_range(0, 2) == 0) begin
          set_op(i, rnd(), rnd());
          req[i] = 1'b1;
        end
      end
      tick();
    end
    rst = 1'b0; req = '0;
    tick();
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter: N_REQ, 4, number of requesters sharing one external 32-bit adder (Adder_32).
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: req  input  N_REQ  per-requester add request, level.
REQ-005 Port: op_a  input  32*N_REQ  operand A; requester i occupies bits [32*i+31:32*i].
REQ-006 Port: op_b  input  32*N_REQ  operand B; same packing as op_a.
REQ-007 Port: gnt  output  N_REQ  one-hot grant pulse, one cycle; marks operand capture.
REQ-008 Port: add_a  output  32  operand A driven to the external adder A input.
REQ-009 Port: add_b  output  32  operand B driven to the external adder B input.
REQ-010 Port: add_s  input  32  sum returned from the external adder S output (combinational).
REQ-011 Port: add_c  input  1  carry-out returned from the external adder C output.
REQ-012 Port: sum  output  32  registered result.
REQ-013 Port: carry  output  1  registered carry-out.
REQ-014 Port: done  output  1  one-cycle pulse; sum/carry/done_id are valid this cycle.
REQ-015 Port: done_id  output  2  index of the requester owning the result (width clog2(N_REQ)).
REQ-016 Port: busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE and DONE, registered.
REQ-018 IDLE: if any req bit is high at a rising edge, select a winner, pulse gnt for the winner, latch op_a/op_b slices into internal operand registers, latch winner index, and go to ISSUE; otherwise stay in IDLE.
REQ-019 gnt SHALL be high for exactly the first cycle of ISSUE and zero in all other cycles.
REQ-020 ISSUE: add_a/add_b SHALL equal the latched operands; at the end of the cycle, capture add_s into sum and add_c into carry, then go to DONE.
REQ-021 DONE: done SHALL be high for one cycle with done_id = latched index; the next state SHALL be IDLE.
REQ-022 Latency: req sampled at edge k -> gnt high in cycle k+1 -> done high in cycle k+2 -> IDLE in cycle k+3; peak throughput one add per 3 cycles.
REQ-023 Arbitration SHALL be round-robin: search starts at (last_winner+1) mod N_REQ; last_winner updates only on grant.
REQ-024 After reset last_winner SHALL be N_REQ-1, so requester 0 has first priority.
REQ-025 Requests arriving in ISSUE or DONE SHALL be ignored and not queued; a requester holds req until it sees its gnt bit.
REQ-026 A requester whose req drops before grant SHALL NOT be served; operand changes after gnt SHALL NOT affect the result in flight.
REQ-027 sum/carry/done_id SHALL hold their values until the next capture; done is the only validity qualifier.
REQ-028 add_a/add_b SHALL hold the last latched operands outside ISSUE; they are not qualified.
REQ-029 Arithmetic is unsigned 32-bit; {carry,sum} = op_a + op_b; wrap-around is reported only through carry.

Reset
REQ-030 rst at a rising edge SHALL force IDLE, set gnt=0, done=0, busy=0, sum=0, carry=0, done_id=0, add_a=0, add_b=0 and last_winner=N_REQ-1.
REQ-031 rst in ISSUE or DONE SHALL abort the operation; no done pulse is produced for the aborted request.
REQ-032 rst has priority over every other event in the same cycle.

Verification
REQ-033 Single request: req=0001, A0=0xFFFFFFFF, B0=0xFFFFFFFF -> gnt=0001 one cycle later; done one cycle after that with sum=0xFFFFFFFE, carry=1, done_id=0.
REQ-034 Contention: req=1111 held, distinct operands per requester -> grant order 0,1,2,3,0; done pulses 3 cycles apart; each sum matches its own operands.
REQ-035 Round-robin skip: last winner 1, req=1001 -> requester 3 granted before requester 0.
REQ-036 Operand change after grant: A2=5, B2=7, then op_a changes to 100 in the gnt cycle -> sum=12, carry=0, done_id=2.
REQ-037 Reset mid-operation: rst asserted in the ISSUE cycle -> no done pulse, all outputs 0 next cycle, next grant goes to requester 0.
REQ-038 Zero operands: A1=0, B1=0 -> sum=0, carry=0, done_id=1, busy high for exactly 2 cycles.
